// File: rtl/ex_stage.sv
// Execute stage of the RV32 pipeline: operand forwarding, ALU, branch/jump resolution
// and the EX/MEM pipeline register.
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [XLEN-1:0] rd1E,
  input  logic [XLEN-1:0] rd2E,
  input  logic [XLEN-1:0] pcE,
  input  logic [31:0]     rdE,
  input  logic [XLEN-1:0] extImmE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic            regWriteE,
  input  logic            memWriteE,
  input  logic            jumpE,
  input  logic            branchE,
  input  logic            ALUsrcE,
  input  logic [3:0]      ALUcontrolE,
  input  logic [1:0]      ResultSrcE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      rdM,
  output logic            regWriteM,
  output logic            memWriteM,
  output logic [1:0]      ResultSrcM
);

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluAnd  = 4'b0010,
    AluOr   = 4'b0011,
    AluXor  = 4'b0100,
    AluSlt  = 4'b0101,
    AluSltu = 4'b0110,
    AluSll  = 4'b0111,
    AluSrl  = 4'b1000,
    AluSra  = 4'b1001,
    AluLui  = 4'b1010
  } alu_op_e;

  logic [XLEN-1:0] w_src_a;
  logic [XLEN-1:0] w_write_data;
  logic [XLEN-1:0] w_src_b;
  logic [XLEN-1:0] w_alu_result;
  logic [4:0]      w_shamt;
  logic            w_zero;
  logic            w_unused_rd;

  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_write_data;
  logic [XLEN-1:0] r_pc_plus4;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_mem_write;
  logic [1:0]      r_result_src;

  // Upper destination-index bits are carried by ID/EX but have no meaning here.
  assign w_unused_rd = ^rdE[31:5];

  // Code 11 is not produced by the hazard unit; it falls back to the register-file value.
  always_comb begin
    w_src_a = rd1E;
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = r_alu_result;
      default: w_src_a = rd1E;
    endcase
  end

  always_comb begin
    w_write_data = rd2E;
    case (ForwardBE)
      2'b01:   w_write_data = ResultW;
      2'b10:   w_write_data = r_alu_result;
      default: w_write_data = rd2E;
    endcase
  end

  assign w_src_b = ALUsrcE ? extImmE : w_write_data;
  assign w_shamt = w_src_b[4:0];

  always_comb begin
    w_alu_result = '0;
    case (ALUcontrolE)
      AluAdd:  w_alu_result = w_src_a + w_src_b;
      AluSub:  w_alu_result = w_src_a - w_src_b;
      AluAnd:  w_alu_result = w_src_a & w_src_b;
      AluOr:   w_alu_result = w_src_a | w_src_b;
      AluXor:  w_alu_result = w_src_a ^ w_src_b;
      AluSlt:  w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
      AluSltu: w_alu_result = {{(XLEN-1){1'b0}}, w_src_a < w_src_b};
      AluSll:  w_alu_result = w_src_a << w_shamt;
      AluSrl:  w_alu_result = w_src_a >> w_shamt;
      AluSra:  w_alu_result = $unsigned($signed(w_src_a) >>> w_shamt);
      AluLui:  w_alu_result = w_src_b;
      default: w_alu_result = '0;
    endcase
  end

  assign w_zero    = (w_alu_result == '0);
  assign PCTargetE = pcE + extImmE;
  assign PCSrcE    = jumpE | (branchE & w_zero);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_alu_result <= '0;
      r_write_data <= '0;
      r_pc_plus4   <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= '0;
    end else begin
      r_alu_result <= w_alu_result;
      r_write_data <= w_write_data;
      r_pc_plus4   <= PCPlus4E;
      r_rd         <= rdE[4:0];
      r_reg_write  <= regWriteE;
      r_mem_write  <= memWriteE;
      r_result_src <= ResultSrcE;
    end
  end

  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign PCPlus4M   = r_pc_plus4;
  assign rdM        = r_rd;
  assign regWriteM  = r_reg_write;
  assign memWriteM  = r_mem_write;
  assign ResultSrcM = r_result_src;

endmodule
